// File: rtl/uart_seq_sender.sv
// UART character sequencer: arm, step an index, fire; sends the mapped character rep times as 8N1 frames.
// Optional CR/LF trailer after the last repeat is enabled by defining UART_SEQ_CRLF_EN.
module uart_seq_sender #(
  parameter int D       = 234,
  parameter int L       = 8,
  parameter int N_CHARS = 27,
  parameter int REP_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sed,
  input  logic             i_cnt,
  input  logic [REP_W-1:0] i_rep,
  output logic             o_txd,
  output logic             o_busy,
  output logic             o_led,
  output logic [4:0]       o_sel,
  output logic             o_done
);
  localparam int BW = $clog2(D);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, START, DATA, STOP, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sed_sync_q, cnt_sync_q;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [7:0]       char_q, char_d;
  logic [4:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             led_q;
  logic             sed_rise, cnt_rise, baud_last;
`ifdef UART_SEQ_CRLF_EN
  logic [1:0]       trl_q, trl_d;
`endif

  // Bit 0 is the first synchroniser stage, bit 2 the history flop.
  assign sed_rise  = sed_sync_q[1] & ~sed_sync_q[2];
  assign cnt_rise  = cnt_sync_q[1] & ~cnt_sync_q[2];
  assign baud_last = (baud_q == BW'(D - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      sed_sync_q <= '0;
      cnt_sync_q <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      rep_q      <= '0;
      char_q     <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      led_q      <= 1'b0;
`ifdef UART_SEQ_CRLF_EN
      trl_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sed_sync_q <= {sed_sync_q[1:0], i_sed};
      cnt_sync_q <= {cnt_sync_q[1:0], i_cnt};
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      rep_q      <= rep_d;
      char_q     <= char_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      led_q      <= (state_q == SELECT);
`ifdef UART_SEQ_CRLF_EN
      trl_q      <= trl_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    char_d  = char_q;
    sel_d   = sel_q;
`ifdef UART_SEQ_CRLF_EN
    trl_d   = trl_q;
`endif
    case (state_q)
      IDLE: begin
        if (sed_rise) begin
          state_d = SELECT;
          sel_d   = '0;
        end
      end
      SELECT: begin
        // A send request outranks a simultaneous step, so the pre-step index is sent.
        if (sed_rise && sel_q != 5'd0) begin
          state_d = LOAD;
        end else if (cnt_rise) begin
          sel_d = (sel_q == 5'(N_CHARS)) ? 5'd0 : sel_q + 5'd1;
        end
      end
      LOAD: begin
        char_d  = (sel_q == 5'd1) ? 8'h20 : 8'h5F + {3'b000, sel_q};
        rep_d   = (i_rep == '0) ? REP_W'(1) : i_rep;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
`ifdef UART_SEQ_CRLF_EN
        trl_d   = 2'd0;
`endif
      end
      START: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'(L - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          if (rep_q > REP_W'(1)) begin
            rep_d   = rep_q - REP_W'(1);
            state_d = START;
          end else begin
            if (rep_q != '0) rep_d = rep_q - REP_W'(1);
`ifdef UART_SEQ_CRLF_EN
            if (trl_q == 2'd0) begin
              char_d  = 8'h0D;
              trl_d   = 2'd1;
              state_d = START;
            end else if (trl_q == 2'd1) begin
              char_d  = 8'h0A;
              trl_d   = 2'd2;
              state_d = START;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign o_txd  = (state_q == START) ? 1'b0 :
                  (state_q == DATA)  ? char_q[bit_q] : 1'b1;
  assign o_busy = busy_q;
  assign o_led  = led_q;
  assign o_sel  = sel_q;
  assign o_done = (state_q == DONE);
endmodule

// File: tb/tb_uart_seq_sender.sv
// Randomised self-checking bench for uart_seq_sender; expected waveforms come from a frame-level model.
module tb_uart_seq_sender;
  localparam int D  = 4;
  localparam int L  = 8;
  localparam int NC = 27;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, sed, cnt;
  logic [RW-1:0] rep;
  logic          txd, busy, led, done;
  logic [4:0]    sel;

  int checks = 0;
  int errors = 0;
  int model_sel = 0;

  uart_seq_sender #(.D(D), .L(L), .N_CHARS(NC), .REP_W(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_sed(sed), .i_cnt(cnt), .i_rep(rep),
    .o_txd(txd), .o_busy(busy), .o_led(led), .o_sel(sel), .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] char_of(int k);
    return (k == 1) ? 8'h20 : 8'(32'h5F + k);
  endfunction

  task automatic pulse_sed();
    sed = 1'b1; repeat (3) @(negedge clk);
    sed = 1'b0; repeat (3) @(negedge clk);
  endtask

  task automatic pulse_cnt();
    cnt = 1'b1; repeat (3) @(negedge clk);
    cnt = 1'b0; repeat (3) @(negedge clk);
  endtask

  task automatic arm();
    pulse_sed();
    model_sel = 0;
    checks++;
    if (led !== 1'b1 || sel !== 5'd0) begin
      errors++;
      $display("FAIL arm: led=%b sel=%0d, required led=1 sel=0", led, sel);
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      pulse_cnt();
      model_sel = (model_sel == NC) ? 0 : model_sel + 1;
    end
    checks++;
    if (sel !== 5'(model_sel)) begin
      errors++;
      $display("FAIL step: sel=%0d, required %0d", sel, model_sel);
    end
  endtask

  // Fire the send and check latency, full serial waveform, busy span and done pulse.
  task automatic fire(int rep_in, bit with_cnt);
    logic [7:0] frames[$];
    logic       exp_bits[$];
    logic       got_bits[$];
    int lat, nrep, mism, early_done;
    lat = 0; mism = 0; early_done = 0;
    nrep = (rep_in == 0) ? 1 : rep_in;
    for (int i = 0; i < nrep; i++) frames.push_back(char_of(model_sel));
`ifdef UART_SEQ_CRLF_EN
    frames.push_back(8'h0D);
    frames.push_back(8'h0A);
`endif
    foreach (frames[f]) begin
      logic [7:0] c;
      c = frames[f];
      for (int k = 0; k < D; k++) exp_bits.push_back(1'b0);
      for (int b = 0; b < L; b++)
        for (int k = 0; k < D; k++) exp_bits.push_back(c[b]);
      for (int k = 0; k < D; k++) exp_bits.push_back(1'b1);
    end
    rep = RW'(rep_in);
    sed = 1'b1;
    cnt = with_cnt;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin lat = c; break; end
    end
    sed = 1'b0;
    cnt = 1'b0;
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency: busy after %0d cycles, required 4", lat);
      return;
    end
    while (busy === 1'b1 && got_bits.size() < 4000) begin
      got_bits.push_back(txd);
      if (done !== 1'b0) early_done++;
      @(negedge clk);
    end
    checks++;
    if (got_bits.size() != exp_bits.size()) begin
      errors++;
      $display("FAIL busy_len: %0d cycles, required %0d", got_bits.size(), exp_bits.size());
    end
    foreach (exp_bits[i])
      if (i < got_bits.size() && got_bits[i] !== exp_bits[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL waveform: %0d wrong bit-cycles for sel=%0d rep=%0d, required 0", mism, model_sel, rep_in);
    end
    checks++;
    if (done !== 1'b1 || early_done != 0) begin
      errors++;
      $display("FAIL done_rise: done=%b early=%0d, required done=1 early=0", done, early_done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || sel !== 5'(model_sel) || txd !== 1'b1) begin
      errors++;
      $display("FAIL done_end: done=%b sel=%0d txd=%b, required 0/%0d/1", done, sel, txd, model_sel);
    end
    $display("sequence sel=%0d rep=%0d frames=%0d cycles=%0d", model_sel, rep_in, frames.size(), got_bits.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; sed = 1'b0; cnt = 1'b0; rep = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || led !== 1'b0 || sel !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: txd=%b busy=%b led=%b sel=%0d done=%b, required 1 0 0 0 0", txd, busy, led, sel, done);
    end
    rst = 1'b0;
    @(negedge clk);
    pulse_cnt(); pulse_cnt();
    checks++;
    if (sel !== 5'd0 || led !== 1'b0) begin
      errors++;
      $display("FAIL idle_cnt: sel=%0d led=%b, required sel=0 led=0", sel, led);
    end
  endtask

  task automatic test_basic();
    arm(); step(3); fire(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    arm(); step(27); fire(3, 1'b0);
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    arm(); step(28);
    sed = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) sed = 1'b0;
      if (busy !== 1'b0 || txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || led !== 1'b1 || sel !== 5'd0) begin
      errors++;
      $display("FAIL wrap_zero_send: bad=%0d led=%b sel=%0d, required 0 1 0", bad, led, sel);
    end
    step(1);
    fire(1, 1'b0);
  endtask

  task automatic test_simultaneous();
    arm(); step(4); fire(1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    arm(); step(2);
    rep = RW'(1);
    sed = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin seen = 1; break; end
    end
    sed = 1'b0;
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL reset_mid_start: busy=%b, required 1", busy);
    end
    repeat (5 * D + 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || sel !== 5'd0 || done !== 1'b0 || led !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: txd=%b busy=%b sel=%0d done=%b led=%b, required 1 0 0 0 0", txd, busy, sel, done, led);
    end
    @(negedge clk);
    rst = 1'b0;
    model_sel = 0;
    repeat (2) @(negedge clk);
    arm(); step(5); fire(2, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int n, r;
      n = $urandom_range(1, 30);
      r = $urandom_range(0, 3);
      if (n == 28) n = 29;
      arm(); step(n); fire(r, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_seq_sender.md
# uart_seq_sender

Self-contained UART character sequencer with integrated transmitter, clocked by `i_clk`.
- Operator arms the block with `i_sed`, steps a character index with `i_cnt` pulses, then fires `i_sed` again.
- The selected character is sent `max(i_rep,1)` times back-to-back as 8N1-style frames.
- Successor of the single-character alphabet sender. It adds synchronised inputs in one clock domain, an index wrap parameter, a repeat count, a configurable data width, a done strobe and an optional CR/LF trailer.

## Interface
- `D`, 234, `i_clk` cycles per UART bit (≥2)
- `L`, 8, data bits per frame (5..8); low `L` bits of the character, LSB first
- `N_CHARS`, 27, highest selectable index (1..27); index wraps `N_CHARS`→0
- `REP_W`, 4, width of repeat count input
- `i_clk`  in  1  sole clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_sed`  in  1  arm/send request, asynchronous, rising-edge sensitive
- `i_cnt`  in  1  index step, asynchronous, rising-edge sensitive
- `i_rep`  in  REP_W  repeat count, sampled when sending starts; 0 treated as 1
- `o_txd`  out  1  serial output, idle high
- `o_busy`  out  1  high from LOAD through end of last stop bit
- `o_led`  out  1  high while in SELECT (registered)
- `o_sel`  out  5  current index
- `o_done`  out  1  one-cycle pulse when sequence completes

## Operation
- `i_sed` and `i_cnt` each pass through a 2-flop synchroniser plus a history flop. `rise = s2 & ~s3`.
- Character map:
  - index 1 → 8'h20 (space)
  - index k (2..27) → 8'h5F+k ('a'..'z')
  - index 0 → never sent
- States:
  - IDLE: `i_cnt` ignored. `i_sed` rise → SELECT, `o_sel`←0.
  - SELECT: `i_cnt` rise → `o_sel`←(`o_sel`==`N_CHARS` ? 0 : `o_sel`+1). `i_sed` rise with `o_sel`≠0 → LOAD. `i_sed` rise with `o_sel`==0 is ignored; the block stays in SELECT.
  - LOAD: latch the character and rep=max(`i_rep`,1); set `o_busy`.
  - START: `o_txd`=0 for D cycles.
  - DATA: L bits, D cycles each.
  - STOP: `o_txd`=1 for D cycles, then one of:
    - remaining frames → START (no gap)
    - else → DONE
  - DONE: `o_done`=1 for one cycle, `o_busy`←0, → IDLE; `o_sel` retained.
- In LOAD..DONE, `i_sed` and `i_cnt` rises are discarded and `o_sel` is frozen.
- Arithmetic:
  - Baud counter width is $clog2(D), counting 0..D-1.
  - Bit counter width is 3.
  - Repeat counter width is REP_W. It is loaded with max(`i_rep`,1) and decremented at each STOP end; it never underflows.
- Simultaneous `i_sed` and `i_cnt` rise in SELECT: the send wins, using the pre-increment `o_sel`.

## Timing
- Reset values:
  - `o_txd`=1
  - `o_busy`=0
  - `o_led`=0
  - `o_sel`=0
  - `o_done`=0
  - state IDLE; synchroniser flops 0
- `i_sed` first sampled high at edge n while in SELECT → LOAD at edge n+2, `o_txd` low from edge n+3.
- `o_led` lags the SELECT state by one cycle.
- Frame length is (2+L)·D cycles. Total send time is rep·(2+L)·D, plus 2·(2+L)·D with the macro.
- `o_done` is asserted in the cycle after the last stop bit's D-th cycle. `o_busy` falls on the same edge that `o_done` rises.
- `i_rst` mid-operation: at the next edge, all outputs return to their reset values, including `o_txd`=1, even mid-bit.
- `i_sed`/`i_cnt` pulses must be ≥2 `i_clk` cycles high and ≥2 low to be seen.

## Configuration
- `UART_SEQ_CRLF_EN`:
  - Defined: after the final repeat, two extra frames 8'h0D then 8'h0A are sent, still within `o_busy`; `o_done` follows the LF stop bit.
  - Undefined: no trailer; STOP of the last repeat → DONE directly.

## Test plan
- Reset with D=4, L=8 → `o_txd`=1, `o_busy`=0, `o_led`=0, `o_sel`=0, `o_done`=0; `i_cnt` pulses in IDLE leave `o_sel`=0.
- `i_sed`, 3× `i_cnt`, `i_sed`, `i_rep`=0 → `o_sel`=3; one 40-cycle frame of 8'h62 (bits 0,0,1,0,0,0,1,1,0,1); `o_done` pulse once.
- `o_sel`=27, `i_rep`=3 → three contiguous frames of 8'h7A, `o_busy` high for exactly 120 cycles, no idle gap between stop and start.
- In SELECT, 28 `i_cnt` pulses with `N_CHARS`=27 → `o_sel`=0; `i_sed` → remains in SELECT, `o_txd` stays 1, `o_busy`=0.
- `i_rst` asserted during DATA bit 4 → next edge `o_txd`=1, `o_busy`=0, `o_sel`=0; a subsequent full sequence transmits correctly.
- With `UART_SEQ_CRLF_EN`, `o_sel`=2, `i_rep`=1 → frames 8'h61, 8'h0D, 8'h0A back-to-back (120 cycles), then `o_done`.
